display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, the number of multiplexed seven-segment digits (range 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, the clk cycles each digit is held (minimum 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port load, input, 1, a one-cycle strobe capturing value_in and err_in.
REQ-006 The block SHALL have port value_in, input, 4*DIGITS, a packed BCD value; nibble 0 is the least significant digit.
REQ-007 The block SHALL have port err_in, input, 1, an error indication captured with value_in.
REQ-008 The block SHALL have port ready, output, 1, high when no captured value is pending.
REQ-009 The block SHALL have port Y, output, 4, the digit code fed to the seven-segment decoder.
REQ-010 The block SHALL have port ErrorFlag, output, 1, the error indication fed to the decoder.
REQ-011 The block SHALL have port digit_sel, output, DIGITS, an active-low one-cold digit enable.

Function
REQ-012 A prescaler SHALL count 0..SCAN_DIV-1 and assert an internal tick on terminal count.
REQ-013 On tick, digit index idx SHALL advance by 1 and wrap DIGITS-1 -> 0; the wrap defines the frame boundary.
REQ-014 A load SHALL write value_in/err_in to the shadow registers and set pending (ready=0) the next cycle.
REQ-015 A load while pending SHALL overwrite the shadow; only the last value is displayed.
REQ-016 At a frame-boundary tick with pending set, shadow SHALL be copied to active and pending SHALL clear (ready=1).
REQ-017 A load in the same cycle as a frame-boundary tick SHALL have the old shadow transferred to active, the new data written to shadow, and pending remaining 1.
REQ-018 digit_sel SHALL be low only at bit idx; Y SHALL be the active nibble idx; both SHALL derive from the same registers so they never disagree.
REQ-019 ErrorFlag SHALL be 1 when the active error bit is 1 or any active nibble exceeds 9.
REQ-020 Y, digit_sel and ErrorFlag SHALL change in the cycle after the tick (one-cycle latency from tick).

Reset
REQ-021 rst_n low SHALL immediately clear prescaler, idx, shadow, active, error and pending.
REQ-022 Reset values SHALL be: Y=0, ErrorFlag=0, ready=1, digit_sel with bit 0 low and all other bits high.
REQ-023 Reset asserted mid-frame SHALL discard any pending value; scanning SHALL restart at digit 0, count 0.

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined, a zero nibble at or above the most significant nonzero active digit SHALL drive Y=4'hF (blank).
REQ-025 Under LEADING_ZERO_BLANK_EN, digit 0 is never blanked, and no blanking applies while ErrorFlag=1.
REQ-026 Without LEADING_ZERO_BLANK_EN, every digit SHALL show its nibble unchanged.

Structure
REQ-027 Package display_pkg SHALL hold BCD_W=4, BLANK_CODE=4'hF and the maximum DIGITS constant.
REQ-028 The prescaler SHALL be the sub-module scan_prescaler (parameter SCAN_DIV, output tick).

Verification (DIGITS=4, SCAN_DIV=4)
REQ-029 Reset release -> Y=0, digit_sel=4'b1110, ErrorFlag=0, ready=1; digit_sel=4'b1101 one cycle after the 4th tick-count cycle.
REQ-030 load value 16'h1234 mid-frame -> ready=0 until the next wrap; the following frame shows Y=4,3,2,1 on digit_sel 1110,1101,1011,0111.
REQ-031 Two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is ever displayed.
REQ-032 load with err_in=1, or value 16'h00A5 -> ErrorFlag=1 for the entire next frame.
REQ-033 LEADING_ZERO_BLANK_EN with 16'h0070 -> Y=0,7,F,F; 16'h0000 -> Y=0,F,F,F; the same values without the macro show all zeros unblanked.
REQ-034 load coincident with the frame-wrap tick, and rst_n pulsed mid-frame -> the coincident case follows REQ-017; after the reset pulse the REQ-022 values hold and the pending value is never shown.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared constants and helpers for the multiplexed seven-segment scanner.
//
//   Contents:
//     BCD_W       width of one BCD digit code
//     BLANK_CODE  digit code the downstream decoder renders as an unlit digit
//     MIN_DIGITS  smallest supported number of multiplexed digits
//     MAX_DIGITS  largest supported number of multiplexed digits
//     BCD_MAX     largest legal BCD digit value
//     bcd_invalid returns 1 when a nibble is not a legal BCD digit
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int BCD_W      = 4;
    localparam int MIN_DIGITS = 2;
    localparam int MAX_DIGITS = 8;

    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
    localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;

    // A nibble above 9 cannot be shown as a decimal digit; the scanner turns
    // that into an error indication rather than passing garbage through.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] nib);
        return (nib > BCD_MAX);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
//   Free-running modulo-SCAN_DIV counter that produces the digit-advance tick.
//   The counter runs 0 .. SCAN_DIV-1 and tick is high for the whole cycle in
//   which the counter sits at its terminal value, so the consumer sees exactly
//   one tick per SCAN_DIV clock cycles.
//
//   Parameters:
//     SCAN_DIV  clk cycles per tick period (minimum 2)
//
//   Ports:
//     clk    in   single clock, rising edge
//     rst_n  in   asynchronous active-low reset; counter returns to 0
//     tick   out  high during the terminal-count cycle
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
//   Time-multiplexed driver for DIGITS seven-segment digits. A BCD value is
//   captured into a shadow register on load and promoted to the displayed
//   (active) register only at a frame boundary, so a frame never mixes digits
//   from two different values.
//
//   Optional build macro:
//     LEADING_ZERO_BLANK_EN  blank (Y = BLANK_CODE) zero digits above the most
//                            significant nonzero digit; digit 0 is never
//                            blanked and nothing is blanked while ErrorFlag=1.
//
//   Parameters:
//     DIGITS    number of multiplexed digits (2..8)
//     SCAN_DIV  clk cycles each digit is held (minimum 2)
//
//   Ports:
//     clk        in   single clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     load       in   one-cycle strobe capturing value_in and err_in
//     value_in   in   packed BCD value, nibble 0 = least significant digit
//     err_in     in   error indication captured together with value_in
//     ready      out  high when no captured value is waiting for a frame
//     Y          out  digit code for the seven-segment decoder
//     ErrorFlag  out  error indication for the decoder
//     digit_sel  out  active-low one-cold digit enable
//
//   Handshake: load/ready is a status handshake, not a blocking one. A load is
//   accepted in every cycle regardless of ready; ready only reports that the
//   last captured value has already reached the display. Loads issued while
//   ready=0 overwrite the waiting value, so only the latest one is shown.
// -----------------------------------------------------------------------------
module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] value_in,
    input  logic                    err_in,
    output logic                    ready,
    output logic [BCD_W-1:0]        Y,
    output logic                    ErrorFlag,
    output logic [DIGITS-1:0]       digit_sel
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = BCD_W * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             tick;
    logic             frame_wrap;

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [VAL_W-1:0] shadow_q;
    logic [VAL_W-1:0] shadow_d;
    logic             shadow_err_q;
    logic             shadow_err_d;
    logic [VAL_W-1:0] active_q;
    logic [VAL_W-1:0] active_d;
    logic             active_err_q;
    logic             active_err_d;
    logic             pending_q;
    logic             pending_d;

    // -------------------------------------------------------------------------
    // Digit-rate tick
    // -------------------------------------------------------------------------
    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // The tick that moves idx from the last digit back to digit 0 is the only
    // point where a new value may enter the display.
    assign frame_wrap = tick && (idx_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        active_d     = active_q;
        active_err_d = active_err_q;
        pending_d    = pending_q;

        if (tick) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Promotion reads the shadow as it was before this edge, so a load in
        // the same cycle still sends the older value to the display.
        if (frame_wrap && pending_q) begin
            active_d     = shadow_q;
            active_err_d = shadow_err_q;
            pending_d    = 1'b0;
        end

        // Placed after the promotion so a coincident load leaves pending set.
        if (load) begin
            shadow_d     = value_in;
            shadow_err_d = err_in;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_err_q <= 1'b0;
            active_q     <= '0;
            active_err_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            active_q     <= active_d;
            active_err_q <= active_err_d;
            pending_q    <= pending_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from idx_q and the active registers, so the enable
    // and the digit code move together on the edge after a tick.
    // -------------------------------------------------------------------------
    logic [BCD_W-1:0] act_nib [DIGITS];
    logic [BCD_W-1:0] y_raw;
    logic             any_bad;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            act_nib[i] = active_q[i*BCD_W +: BCD_W];
        end
    end

    always_comb begin
        digit_sel = '1;
        y_raw     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel[i] = 1'b0;
                y_raw        = act_nib[i];
            end
        end
    end

    // The error covers the whole frame, not just the offending digit.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_bad = any_bad | bcd_invalid(act_nib[i]);
        end
    end

    assign ErrorFlag = active_err_q | any_bad;
    assign ready     = ~pending_q;

`ifdef LEADING_ZERO_BLANK_EN
    // zero_above[i] is set when digit i and every digit above it are zero,
    // i.e. digit i is a leading zero.
    logic [DIGITS-1:0] zero_above;
    logic              zero_run;
    logic              blank;

    always_comb begin
        zero_run   = 1'b1;
        zero_above = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (act_nib[i] == '0);
            zero_above[i] = zero_run;
        end
    end

    // Digit 0 is left out of the search so an all-zero value still shows "0".
    always_comb begin
        blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                blank = zero_above[i];
            end
        end
    end

    // An error frame is shown raw so the fault stays visible.
    assign Y = (blank && !ErrorFlag) ? BLANK_CODE : y_raw;
`else
    assign Y = y_raw;
`endif

endmodule
